// File: rtl/calc_pkg.sv
// Shared types and constants for the UART calculator frame controller.
package calc_pkg;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_OP_CHK   = 4'd1,
      ST_NAK      = 4'd2,
      ST_NAK_WAIT = 4'd3,
      ST_A_LO     = 4'd4,
      ST_A_HI     = 4'd5,
      ST_ACK      = 4'd6,
      ST_ACK_WAIT = 4'd7,
      ST_B_LO     = 4'd8,
      ST_B_HI     = 4'd9,
      ST_CALC     = 4'd10,
      ST_TX_RES   = 4'd11
   } state_e;

   localparam logic [7:0] OP_ADD   = 8'h00;
   localparam logic [7:0] OP_SUB   = 8'h01;
   localparam logic [7:0] OP_AND   = 8'h02;
   localparam logic [7:0] OP_OR    = 8'h03;

   localparam logic [7:0] ACK_BYTE = 8'h06;
   localparam logic [7:0] NAK_BYTE = 8'h15;

endpackage

// File: rtl/calc_alu.sv
// Combinational calculator ALU: 17-bit result (bit 16 = carry/borrow) and opcode validity.
module calc_alu
   import calc_pkg::*;
(
   input  logic [7:0]  op_i,
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   output logic [16:0] res_o,
   output logic        valid_op_o
);

   always_comb begin
      res_o      = 17'd0;
      valid_op_o = 1'b1;
      case (op_i)
         OP_ADD:  res_o = {1'b0, a_i} + {1'b0, b_i};
         OP_SUB:  res_o = {1'b0, a_i} - {1'b0, b_i};
         OP_AND:  res_o = {1'b0, a_i & b_i};
         OP_OR:   res_o = {1'b0, a_i | b_i};
         default: valid_op_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/uart_calc_ctrl.sv
// UART calculator frame controller: assembles OP/A/B, computes, replies over UART.
// Optional inter-byte timeout enabled by defining CALC_TIMEOUT_EN.
module uart_calc_ctrl
   import calc_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_ready,
   input  logic        tx_busy,
   output logic [7:0]  tx_data,
   output logic        tx_start,
   output logic [3:0]  state,
   output logic [15:0] a,
   output logic [15:0] b,
   output logic [16:0] res,
   output logic        frame_done
);

   state_e      state_q, state_d;
   logic [7:0]  op_q, op_d;
   logic [15:0] a_q, a_d, b_q, b_d;
   logic [16:0] res_q, res_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        tx_start_q, tx_start_d;
   logic        frame_done_q, frame_done_d;
   logic [1:0]  idx_q, idx_d;
   logic        wait_q, wait_d;
   logic [16:0] alu_res;
   logic        alu_valid;
   logic        tmo_hit;

   calc_alu u_alu (
      .op_i       (op_q),
      .a_i        (a_q),
      .b_i        (b_q),
      .res_o      (alu_res),
      .valid_op_o (alu_valid)
   );

`ifdef CALC_TIMEOUT_EN
   logic [26:0] tmo_q, tmo_d;
   logic        tmo_run;

   always_comb begin
      tmo_run = (state_q == ST_A_LO) || (state_q == ST_A_HI) ||
                (state_q == ST_B_LO) || (state_q == ST_B_HI);
      tmo_hit = tmo_run && (tmo_q == 27'(TIMEOUT_CYCLES));
      tmo_d   = tmo_q + 27'd1;
      if (!tmo_run || rx_ready || (state_d != state_q)) tmo_d = 27'd0;
   end

   always_ff @(posedge clk) begin
      if (reset) tmo_q <= 27'd0;
      else       tmo_q <= tmo_d;
   end
`else
   logic unused_tmo;
   assign unused_tmo = ^TIMEOUT_CYCLES;
   assign tmo_hit    = 1'b0;
`endif

   // Wait states ignore tx_busy while our own start pulse is still out, since the
   // transmitter only raises busy in the cycle after it sees tx_start.
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      a_d          = a_q;
      b_d          = b_q;
      res_d        = res_q;
      tx_data_d    = tx_data_q;
      tx_start_d   = 1'b0;
      frame_done_d = 1'b0;
      idx_d        = idx_q;
      wait_d       = wait_q;
      case (state_q)
         ST_IDLE: if (rx_ready) begin
            op_d    = rx_data;
            state_d = ST_OP_CHK;
         end
         ST_OP_CHK: if (alu_valid) begin
            a_d     = 16'd0;
            b_d     = 16'd0;
            state_d = ST_A_LO;
         end else begin
            state_d = ST_NAK;
         end
         ST_NAK: if (!tx_busy) begin
            tx_start_d = 1'b1;
            tx_data_d  = NAK_BYTE;
            state_d    = ST_NAK_WAIT;
         end
         ST_NAK_WAIT: if (!tx_busy && !tx_start_q) state_d = ST_IDLE;
         ST_A_LO: if (rx_ready) begin
            a_d[7:0] = rx_data;
            state_d  = ST_A_HI;
         end
         ST_A_HI: if (rx_ready) begin
            a_d[15:8] = rx_data;
            state_d   = ST_ACK;
         end
         ST_ACK: if (!tx_busy) begin
            tx_start_d = 1'b1;
            tx_data_d  = ACK_BYTE;
            state_d    = ST_ACK_WAIT;
         end
         ST_ACK_WAIT: if (!tx_busy && !tx_start_q) state_d = ST_B_LO;
         ST_B_LO: if (rx_ready) begin
            b_d[7:0] = rx_data;
            state_d  = ST_B_HI;
         end
         ST_B_HI: if (rx_ready) begin
            b_d[15:8] = rx_data;
            state_d   = ST_CALC;
         end
         ST_CALC: begin
            res_d   = alu_res;
            idx_d   = 2'd0;
            wait_d  = 1'b0;
            state_d = ST_TX_RES;
         end
         ST_TX_RES: if (wait_q) begin
            if (!tx_busy && !tx_start_q) wait_d = 1'b0;
         end else if (!tx_busy) begin
            tx_start_d = 1'b1;
            case (idx_q)
               2'd0:    tx_data_d = res_q[7:0];
               2'd1:    tx_data_d = res_q[15:8];
               default: tx_data_d = {7'd0, res_q[16]};
            endcase
            wait_d = 1'b1;
            idx_d  = idx_q + 2'd1;
            if (idx_q == 2'd2) begin
               frame_done_d = 1'b1;
               idx_d        = 2'd0;
               wait_d       = 1'b0;
               state_d      = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (tmo_hit) begin
         a_d     = 16'd0;
         b_d     = 16'd0;
         state_d = ST_NAK;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         op_q         <= 8'd0;
         a_q          <= 16'd0;
         b_q          <= 16'd0;
         res_q        <= 17'd0;
         tx_data_q    <= 8'd0;
         tx_start_q   <= 1'b0;
         frame_done_q <= 1'b0;
         idx_q        <= 2'd0;
         wait_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         a_q          <= a_d;
         b_q          <= b_d;
         res_q        <= res_d;
         tx_data_q    <= tx_data_d;
         tx_start_q   <= tx_start_d;
         frame_done_q <= frame_done_d;
         idx_q        <= idx_d;
         wait_q       <= wait_d;
      end
   end

   assign state      = state_q;
   assign a          = a_q;
   assign b          = b_q;
   assign res        = res_q;
   assign tx_data    = tx_data_q;
   assign tx_start   = tx_start_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_calc_ctrl.sv
// Scoreboard bench for uart_calc_ctrl with a behavioural transmitter model.
module tb_uart_calc_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_ready = 1'b0;
   logic        tx_busy;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic [3:0]  state;
   logic [15:0] a, b;
   logic [16:0] res;
   logic        frame_done;

   int errors = 0;
   int checks = 0;
   int busy_cnt = 0;
   int fd_cnt = 0;
   logic        prev_start = 1'b0;
   logic [3:0]  last_state = 4'd0;
   logic [63:0] tr = 64'd0;
   int          tr_n = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  exp_b;

   uart_calc_ctrl #(.TIMEOUT_CYCLES(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .tx_busy    (tx_busy),
      .tx_data    (tx_data),
      .tx_start   (tx_start),
      .state      (state),
      .a          (a),
      .b          (b),
      .res        (res),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;
   assign tx_busy = (busy_cnt != 0);

   // Transmitter model, TX scoreboard and state trace, all sampled on the falling edge.
   always @(negedge clk) begin
      if (busy_cnt != 0) busy_cnt = busy_cnt - 1;
      if (tx_start) begin
         busy_cnt = 4;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL tx_byte: got %02h, no byte expected", tx_data);
         end else begin
            exp_b = exp_q.pop_front();
            if (tx_data !== exp_b) begin
               errors++;
               $display("FAIL tx_byte: got %02h, required %02h", tx_data, exp_b);
            end
         end
         checks++;
         if (prev_start !== 1'b0) begin
            errors++;
            $display("FAIL tx_start_gap: tx_start high two cycles in a row");
         end
      end
      prev_start = tx_start;
      if (frame_done === 1'b1) fd_cnt++;
      if (state !== last_state) begin
         tr = {tr[59:0], state};
         tr_n++;
         last_state = state;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [16:0] model(input logic [7:0] op, input logic [15:0] x, input logic [15:0] y);
      case (op)
         8'h00:   return {1'b0, x} + {1'b0, y};
         8'h01:   return {1'b0, x} - {1'b0, y};
         8'h02:   return {1'b0, x & y};
         8'h03:   return {1'b0, x | y};
         default: return 17'd0;
      endcase
   endfunction

   task automatic clear_trace();
      tr   = {60'd0, state};
      tr_n = 1;
   endtask

   task automatic wait_state(input logic [3:0] s, input int budget);
      int n = 0;
      while (state !== s && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (state !== s) begin
         checks++;
         errors++;
         $display("FAIL wait_state: state=%0d, required %0d within %0d cycles", state, s, budget);
      end
   endtask

   task automatic send_at(input logic [3:0] s, input logic [7:0] d);
      wait_state(s, 200);
      rx_data  = d;
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic run_frame(input logic [7:0] op, input logic [7:0] al, input logic [7:0] ah,
                            input logic [7:0] bl, input logic [7:0] bh, input bit inject);
      logic [16:0] r;
      r = model(op, {ah, al}, {bh, bl});
      exp_q.push_back(8'h06);
      exp_q.push_back(r[7:0]);
      exp_q.push_back(r[15:8]);
      exp_q.push_back({7'd0, r[16]});
      send_at(4'd0, op);
      checks++;
      if (state !== 4'd1) begin errors++; $display("FAIL op_state: state=%0d, required 1", state); end
      send_at(4'd4, al);
      checks++;
      if (state !== 4'd5 || a[7:0] !== al) begin
         errors++; $display("FAIL a_lo: state=%0d a=%04h, required 5 and a[7:0]=%02h", state, a, al);
      end
      send_at(4'd5, ah);
      checks++;
      if (a !== {ah, al}) begin errors++; $display("FAIL a_full: a=%04h, required %04h", a, {ah, al}); end
      if (inject) send_at(4'd7, 8'hAA);
      send_at(4'd8, bl);
      checks++;
      if (state !== 4'd9 || b[7:0] !== bl) begin
         errors++; $display("FAIL b_lo: state=%0d b=%04h, required 9 and b[7:0]=%02h", state, b, bl);
      end
      send_at(4'd9, bh);
      checks++;
      if (state !== 4'd10 || b !== {bh, bl}) begin
         errors++; $display("FAIL b_hi: state=%0d b=%04h, required 10 and %04h", state, b, {bh, bl});
      end
      wait_state(4'd0, 200);
      repeat (3) @(negedge clk);
      checks++;
      if (res !== r) begin errors++; $display("FAIL res_model: res=%05h, required %05h", res, r); end
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL tx_pending: %0d bytes not sent", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      checks++;
      if (state !== 4'd0 || a !== 16'd0 || b !== 16'd0 || res !== 17'd0 ||
          tx_data !== 8'd0 || tx_start !== 1'b0 || frame_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: state=%0d a=%04h b=%04h res=%05h txd=%02h txs=%b fd=%b, required all zero",
                  state, a, b, res, tx_data, tx_start, frame_done);
      end
   endtask

   task automatic test_add();
      int fd0;
      fd0 = fd_cnt;
      clear_trace();
      run_frame(8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 1'b0);
      checks++;
      if (res !== 17'h068AC) begin errors++; $display("FAIL add_res: res=%05h, required 068ac", res); end
      checks++;
      if (tr !== 64'h0145_6789_AB0 || tr_n != 11) begin
         errors++; $display("FAIL add_trace: trace=%0h n=%0d, required 0456789ab0 with leading 0,1 n=11", tr, tr_n);
      end
      checks++;
      if (fd_cnt - fd0 != 1) begin errors++; $display("FAIL add_frame_done: pulses=%0d, required 1", fd_cnt - fd0); end
   endtask

   task automatic test_sub();
      run_frame(8'h01, 8'h01, 8'h00, 8'h02, 8'h00, 1'b0);
      checks++;
      if (res !== 17'h1FFFF) begin errors++; $display("FAIL sub_res: res=%05h, required 1ffff", res); end
   endtask

   task automatic test_invalid();
      logic [16:0] prev;
      prev = res;
      clear_trace();
      exp_q.push_back(8'h15);
      send_at(4'd0, 8'h07);
      wait_state(4'd0, 200);
      repeat (3) @(negedge clk);
      checks++;
      if (res !== prev) begin errors++; $display("FAIL invalid_res: res=%05h, required %05h", res, prev); end
      checks++;
      if (tr !== 64'h01230 || tr_n != 5) begin
         errors++; $display("FAIL invalid_trace: trace=%0h n=%0d, required 1230 n=5", tr, tr_n);
      end
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL invalid_nak: NAK not sent"); exp_q.delete(); end
   endtask

   task automatic test_drop();
      run_frame(8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1);
      checks++;
      if (b !== 16'h4433 || res !== 17'h06644) begin
         errors++; $display("FAIL drop_res: b=%04h res=%05h, required 4433 and 06644", b, res);
      end
   endtask

   task automatic test_back_to_back();
      run_frame(8'h02, 8'hF0, 8'hF0, 8'h3C, 8'h3C, 1'b0);
      checks++;
      if (res !== 17'h03030) begin errors++; $display("FAIL and_res: res=%05h, required 03030", res); end
      run_frame(8'h03, 8'hFF, 8'h00, 8'h00, 8'hFF, 1'b0);
      checks++;
      if (res !== 17'h0FFFF) begin errors++; $display("FAIL or_res: res=%05h, required 0ffff", res); end
      run_frame(8'h00, 8'hFF, 8'hFF, 8'h01, 8'h00, 1'b0);
      checks++;
      if (res !== 17'h10000) begin errors++; $display("FAIL carry_res: res=%05h, required 10000", res); end
   endtask

   task automatic test_timeout();
`ifdef CALC_TIMEOUT_EN
      clear_trace();
      exp_q.push_back(8'h15);
      send_at(4'd0, 8'h00);
      send_at(4'd4, 8'h5A);
      wait_state(4'd0, 100);
      repeat (3) @(negedge clk);
      checks++;
      if (a !== 16'd0 || b !== 16'd0) begin errors++; $display("FAIL timeout_clear: a=%04h b=%04h, required 0", a, b); end
      checks++;
      if (tr !== 64'h0145230 || tr_n != 7) begin
         errors++; $display("FAIL timeout_trace: trace=%0h n=%0d, required 145230 n=7", tr, tr_n);
      end
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL timeout_nak: NAK not sent"); exp_q.delete(); end
`else
      int bad = 0;
      send_at(4'd0, 8'h00);
      send_at(4'd4, 8'h5A);
      for (int i = 0; i < 1000; i++) begin
         if (state !== 4'd5) bad++;
         @(negedge clk);
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL no_timeout: %0d cycles out of state 5, required 0", bad); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
`endif
   endtask

   task automatic test_reset_mid();
      exp_q.push_back(8'h06);
      send_at(4'd0, 8'h00);
      send_at(4'd4, 8'hCD);
      send_at(4'd5, 8'hAB);
      wait_state(4'd8, 200);
      checks++;
      if (tx_busy !== 1'b0 || a !== 16'hABCD) begin
         errors++; $display("FAIL mid_setup: busy=%b a=%04h, required 0 and abcd", tx_busy, a);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (state !== 4'd0 || a !== 16'd0 || b !== 16'd0 || res !== 17'd0 ||
          tx_data !== 8'd0 || tx_start !== 1'b0 || frame_done !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: state=%0d a=%04h b=%04h res=%05h txd=%02h txs=%b fd=%b, required all zero",
                  state, a, b, res, tx_data, tx_start, frame_done);
      end
      run_frame(8'h01, 8'h00, 8'h90, 8'h00, 8'h10, 1'b0);
      checks++;
      if (res !== 17'h08000) begin errors++; $display("FAIL mid_frame: res=%05h, required 08000", res); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_add();
      test_sub();
      test_invalid();
      test_drop();
      test_back_to_back();
      test_timeout();
      test_reset_mid();
      repeat (10) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL final_queue: %0d bytes outstanding", exp_q.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_calc_ctrl.md
# uart_calc_ctrl

Frame controller for the UART calculator. It receives bytes from the UART receiver and assembles the opcode and the two 16-bit operands `a` and `b`. It computes the 17-bit result, answers over the UART transmitter, and publishes a 4-bit `state` code. The display driver consumes `state`, `a`, `b` and `res` to select what the 7-segment display shows.

## Interface
- `TIMEOUT_CYCLES`, default 100_000_000: inter-byte timeout in clock cycles. Used only when `CALC_TIMEOUT_EN` is defined.
- `clk`  in  1  system clock. Single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  received byte. Valid only while `rx_ready`=1.
- `rx_ready`  in  1  one-cycle pulse per received byte.
- `tx_busy`  in  1  transmitter busy. Contract: it is high in the cycle after `tx_start` and stays high until that byte has been sent.
- `tx_data`  out  8  byte to send. Held stable until the next `tx_start`.
- `tx_start`  out  1  one-cycle send pulse.
- `state`  out  4  current FSM state code, 0..11.
- `a`, `b`  out  16  operand registers.
- `res`  out  17  result register. Bit 16 is carry/borrow.
- `frame_done`  out  1  one-cycle pulse when the last result byte has been handed to the transmitter.

## Operation
- Frame format: OP, A_lo, A_hi, B_lo, B_hi.
- Opcodes:
  - 0x00 ADD: `{1'b0,a}+{1'b0,b}`.
  - 0x01 SUB: `{1'b0,a}-{1'b0,b}`, 17-bit wrap, so bit 16 is the borrow.
  - 0x02 AND and 0x03 OR: result in bits 15:0, bit 16 = 0.
  - Any other opcode is invalid.
- States (fixed numeric codes):
  - 0 IDLE: on `rx_ready`, latch op → 1.
  - 1 OP_CHK: valid op → clear `a`, `b` → 4. Invalid op → 2.
  - 2 NAK: when `tx_busy`=0, pulse `tx_start` with `tx_data`=0x15 → 3.
  - 3 NAK_WAIT: on `tx_busy`=0 → 0.
  - 4 A_LO: on `rx_ready`, `a[7:0]`←byte → 5.
  - 5 A_HI: on `rx_ready`, `a[15:8]`←byte → 6.
  - 6 ACK: when `tx_busy`=0, pulse `tx_start` with `tx_data`=0x06 → 7.
  - 7 ACK_WAIT: on `tx_busy`=0 → 8.
  - 8 B_LO: on `rx_ready`, `b[7:0]`←byte → 9.
  - 9 B_HI: on `rx_ready`, `b[15:8]`←byte → 10.
  - 10 CALC: register `res` → 11.
  - 11 TX_RES: send `res[7:0]`, then `res[15:8]`, then `{7'b0,res[16]}`. A 2-bit byte index and a start/wait phase flag pace the sends; each byte waits for `tx_busy`=0. When the third byte is started, pulse `frame_done` → 0.
- Bytes arriving in states 1–3, 6, 7, 10 and 11 are dropped. They do not queue.
- `res` changes only in CALC. An invalid opcode leaves `res` at its previous value.
- The ACK and NAK sends, and each result-byte send, start only when `tx_busy`=0.

## Timing
- Reset values: `state`=0, `a`=0, `b`=0, `res`=0, `tx_data`=0, `tx_start`=0, `frame_done`=0, internal counters and flags = 0.
- Reset asserted in any state takes effect at the next clock edge. The frame is abandoned and no partial transmit is resumed.
- All state transitions are registered. A byte received in state N is visible in `a` or `b` one cycle later, together with the new state.
- `res` is valid in the cycle `state` becomes 11.
- The first result-byte `tx_start` comes no earlier than the second cycle in state 11.
- `tx_start` is never high in two consecutive cycles.

## Configuration
- `CALC_TIMEOUT_EN` defined:
  - A 27-bit counter runs in states 4, 5, 8 and 9. It clears on each `rx_ready` and on every state change.
  - When it reaches `TIMEOUT_CYCLES`, go to 2 (NAK) and clear `a` and `b`.
- `CALC_TIMEOUT_EN` undefined: no counter is built, and these states wait indefinitely.

## Structure
- Package `calc_pkg`:
  - state enum typedef (4-bit, explicit values 0..11);
  - opcode constants (`OP_ADD`, `OP_SUB`, `OP_AND`, `OP_OR`);
  - `ACK_BYTE`=0x06 and `NAK_BYTE`=0x15.
- Sub-module `calc_alu`: combinational; inputs op, `a`, `b`; outputs the 17-bit result and a `valid_op` flag. Its result is registered in CALC.

## Test plan
- ADD, frame 00 34 12 78 56: `a`=0x1234, `b`=0x5678, `res`=0x068AC. TX sequence 06, AC, 68, 00. `state` visits 0,1,4,5,6,7,8,9,10,11,0. One `frame_done` pulse.
- SUB, frame 01 01 00 02 00: `res`=0x1FFFF. TX sequence 06, FF, FF, 01.
- Invalid opcode 07: TX 15 only. `state` visits 1,2,3,0. `res` unchanged from the previous frame.
- Byte 0xAA injected while in state 7: dropped. Next byte lands in `b[7:0]`. Result matches a frame without the injected byte.
- Timeout with `CALC_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16: stall 16 cycles after A_lo gives NAK 15, `a`=0, then `state`=0. With the macro undefined, `state` stays at 5 for 1000 cycles.
- `reset` pulsed while in state 8 with `tx_busy` low: the next cycle shows all outputs at their reset values. A following full frame completes normally.
